out_mem_drain_ctrl: RTL

- Sequences write-back of the single-port output SRAM to DRAM once the output-memory write sequencer pulses out_buf_ready.
- Shares the SRAM port between the write sequencer (always wins) and its own read stream.
- Streams words to the DRAM write interface through a valid/ready handshake with a 2-entry skid buffer.
- Generates DRAM addresses and reports busy, done and overflow to the layer controller.

---
 rtl/out_mem_drain_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/out_mem_drain_ctrl.sv
// out_mem_drain_ctrl
// Drains the output SRAM to DRAM after the write sequencer signals that a
// row group (CONV) or a result vector (FC) is complete.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   conv_or_fc            layer type (00 CONV, 01 FC, others reserved)
//   out_buf_ready         1-cycle drain request
//   wr_en_in, wr_addr_in  write-sequencer SRAM access (always has priority)
//   dram_base(_load)      DRAM byte base address and its load strobe
//   mem_rdata             SRAM read data, one cycle after a read issue
//   mem_addr/en/wen       shared SRAM port
//   dram_w*               DRAM write beat stream (valid/ready)
//   drain_busy/done       status to the layer controller
//   overflow_err          sticky request-while-busy / reserved-type flag
//
// state | meaning
// IDLE  | waiting for out_buf_ready
// READ  | issuing SRAM reads into the skid buffer
// FLUSH | all reads returned, waiting for the last beats to be accepted
module out_mem_drain_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 128,
  parameter int DRAM_ADDR_W = 32,
  parameter int CONV_WORDS  = 7,
  parameter int FC_WORDS    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             conv_or_fc,
  input  logic                   out_buf_ready,
  input  logic                   wr_en_in,
  input  logic [ADDR_W-1:0]      wr_addr_in,
  input  logic [DRAM_ADDR_W-1:0] dram_base,
  input  logic                   dram_base_load,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_en,
  output logic                   mem_wen,
  output logic                   dram_wvalid,
  input  logic                   dram_wready,
  output logic [DATA_W-1:0]      dram_wdata,
  output logic [DRAM_ADDR_W-1:0] dram_waddr,
  output logic                   drain_busy,
  output logic                   drain_done,
  output logic                   overflow_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [1:0] LT_CONV = 2'b00;
  localparam logic [1:0] LT_FC   = 2'b01;

  localparam logic [ADDR_W-1:0]      CONV_LEN   = ADDR_W'(CONV_WORDS);
  localparam logic [ADDR_W-1:0]      FC_LEN     = ADDR_W'(FC_WORDS);
  localparam logic [DRAM_ADDR_W-1:0] BEAT_BYTES = DRAM_ADDR_W'(DATA_W / 8);

  logic [1:0]             state;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W-1:0]      words;
  logic [ADDR_W-1:0]      beat_cnt;
  logic                   inflight;
  logic [1:0]             fifo_cnt;
  logic                   head;
  logic [DATA_W-1:0]      buf0;
  logic [DATA_W-1:0]      buf1;
  logic [DRAM_ADDR_W-1:0] addr_q;
  logic                   ovf_q;

  logic                   pop;
  logic                   push;
  logic                   wr_sel;
  logic [1:0]             occ;
  logic                   rd_issue;
  logic                   last_beat;
  logic                   type_ok;

  assign pop  = (fifo_cnt != 2'd0) & dram_wready;
  assign push = inflight;

  // Slots committed once this cycle's beat leaves: a word popped now frees its
  // slot for a read issued now, which keeps a steady stream at one beat per
  // clock while never holding more than two words (buffered + in flight).
  assign occ      = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
  assign rd_issue = (state == S_READ) & ~wr_en_in & (rd_ptr < words) & (occ < 2'd2);

  assign last_beat = pop & (state != S_IDLE) & (beat_cnt == words - ADDR_W'(1));
  assign type_ok   = (conv_or_fc == LT_CONV) | (conv_or_fc == LT_FC);

  assign mem_wen = wr_en_in;
  assign mem_en  = wr_en_in | rd_issue;
  assign mem_addr = wr_en_in ? wr_addr_in : rd_ptr;

  assign dram_wvalid  = (fifo_cnt != 2'd0);
  assign dram_wdata   = head ? buf1 : buf0;
  assign dram_waddr   = addr_q;
  assign drain_busy   = (state != S_IDLE);
  assign drain_done   = last_beat;
  assign overflow_err = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      words    <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (pop)      beat_cnt <= beat_cnt + ADDR_W'(1);
      case (state)
        S_IDLE: begin
          if (out_buf_ready && type_ok) begin
            words    <= (conv_or_fc == LT_CONV) ? CONV_LEN : FC_LEN;
            rd_ptr   <= '0;
            beat_cnt <= '0;
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (last_beat) state <= S_IDLE;
          else if ((rd_ptr == words) && !inflight) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (last_beat) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry skid buffer; a push never meets a full buffer because reads
  // are only issued when a slot is guaranteed.
  assign wr_sel = head ^ fifo_cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      fifo_cnt <= 2'd0;
      head     <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= rd_issue;
      if (push) begin
        if (wr_sel) buf1 <= mem_rdata;
        else        buf0 <= mem_rdata;
      end
      if (pop) head <= ~head;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // A base load wins over a same-cycle increment; a new error event wins
  // over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (dram_base_load) addr_q <= dram_base;
      else if (pop)       addr_q <= addr_q + BEAT_BYTES;
      if (out_buf_ready && ((state != S_IDLE) || !type_ok)) ovf_q <= 1'b1;
      else if (dram_base_load)                              ovf_q <= 1'b0;
    end
  end

endmodule
